// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - two-press operand capture stage feeding the ripple-carry adder
//
// Captures operand A on the first debounced press of `load`, then operand B and
// carry-in on the second. The operands are held on registered outputs, and `valid`
// flags a complete set.
//
// Ports:
//   clock    - single clock, rising edge
//   resetn   - asynchronous active-low reset
//   data_in  - operand value from the switch bank (WIDTH bits)
//   cin_in   - carry-in switch, captured together with B
//   load     - raw button level, active-high, asynchronous to clock
//   clear    - synchronous clear, active-high, wins over a coincident press
//   a_out    - registered operand A
//   b_out    - registered operand B
//   cin_out  - registered carry-in
//   valid    - high while the state is READY
//   state    - FSM state encoding for status LEDs
module operand_loader #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 250000
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cin_in,
  input  logic             load,
  input  logic             clear,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             cin_out,
  output logic             valid,
  output logic [1:0]       state
);

  // $clog2(1) is 0, so a single-cycle debounce still needs a 1-bit counter.
  localparam int             CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } state_t;

  logic          s1;
  logic          s2;
  logic          db_level;
  logic          db_prev;
  logic [CW-1:0] cnt;
  logic          press;
  state_t        st;

  // Input conditioning: the synchroniser and the debouncer ignore `clear`.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      cnt      <= '0;
    end else begin
      s1      <= load;
      s2      <= s1;
      db_prev <= db_level;
      if (s2 == db_level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db_level <= s2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Only a debounced rising edge counts as a press. A release produces nothing.
  assign press = db_level & ~db_prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st      <= LOAD_A;
      a_out   <= '0;
      b_out   <= '0;
      cin_out <= 1'b0;
      valid   <= 1'b0;
    end else if (clear) begin
      // A press that coincides with clear is dropped.
      st      <= LOAD_A;
      a_out   <= '0;
      b_out   <= '0;
      cin_out <= 1'b0;
      valid   <= 1'b0;
    end else begin
      case (st)
        LOAD_A: begin
          if (press) begin
            a_out <= data_in;
            st    <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (press) begin
            b_out   <= data_in;
            cin_out <= cin_in;
            valid   <= 1'b1;
            st      <= READY;
          end
        end
        READY: begin
          // A press here starts the next operand set with A, so B and carry are cleared.
          if (press) begin
            a_out   <= data_in;
            b_out   <= '0;
            cin_out <= 1'b0;
            valid   <= 1'b0;
            st      <= LOAD_B;
          end
        end
        default: begin
          st    <= LOAD_A;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule
